fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage: owns the program counter, drives the combinational
//   instruction memory address and captures the returned word into the IF/ID
//   pipeline register. Handles stall, flush, branch/jump redirect and optional halt.
//   Sits between the PC-select logic of EX (redirect source) and the decode stage.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) placed in id_instr when invalid
// PORTS
//   clk          in   1   rising-edge clock
//   rst_n        in   1   synchronous active-low reset
//   imem_pc      out  32  byte address to instruction memory (= pc_q, combinational)
//   imem_instr   in   32  instruction word returned same cycle for imem_pc
//   stall        in   1   hold PC and IF/ID contents
//   flush        in   1   invalidate IF/ID on next edge
//   redirect     in   1   load redirect_pc into PC (taken branch/jump)
//   redirect_pc  in   32  redirect target
//   id_valid     out  1   IF/ID holds a real instruction
//   id_pc        out  32  PC of instruction in IF/ID
//   id_instr     out  32  instruction in IF/ID (NOP_INSTR when !id_valid)
//   id_pc_plus4  out  32  id_pc + 4, mod 2^32
//   misalign     out  1   1-cycle pulse: redirect_pc[1:0] != 0
//   halted       out  1   fetch halted on EBREAK
// BEHAVIOUR
//   - One clock; reset synchronous, active-low, highest priority over all inputs.
//   - Reset values: pc_q=RESET_PC, id_valid=0, id_pc=0, id_instr=NOP_INSTR,
//     id_pc_plus4=4, misalign=0, halted=0, state=BOOT.
//   - FSM: BOOT -> RUN unconditionally after 1 cycle (no capture in BOOT);
//     RUN -> HALT on capture of 32'h0010_0073 (only with macro);
//     HALT -> RUN on redirect. Reset from any state -> BOOT.
//   - Latency: instruction at pc_q appears in IF/ID one edge later; first valid
//     id_valid is the 2nd rising edge after rst_n goes high.
//   - Per-edge priority in RUN: redirect > flush > stall > advance.
//     redirect: pc_q<=redirect_pc & ~32'h3; id_valid<=0; id_instr<=NOP_INSTR;
//       overrides stall and flush in the same cycle.
//     flush (no redirect): id_valid<=0, id_instr<=NOP_INSTR; PC advances unless stall.
//     stall (no redirect/flush): pc_q and all id_* hold.
//     advance: id_instr<=imem_instr, id_pc<=pc_q, id_pc_plus4<=pc_q+4,
//       id_valid<=1, pc_q<=pc_q+4.
//   - PC arithmetic 32-bit, wraps: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
//   - misalign<=1 for exactly the cycle after a redirect with redirect_pc[1:0]!=0,
//     else 0; target is still loaded word-aligned.
//   - HALT: pc_q frozen, no captures; on first non-stalled edge id_valid<=0 and
//     id_instr<=NOP_INSTR (stall holds the EBREAK in IF/ID); halted=1 while in HALT.
//   - Reset asserted mid-stall/mid-redirect: reset values win, pending redirect dropped.
// CONFIGURATION
//   FETCH_HALT_EBREAK_EN defined: RUN->HALT transition on EBREAK capture as above.
//   Not defined: HALT unreachable, halted tied 0, EBREAK fetched like any instruction.
// TESTING
//   1 Reset, RESET_PC=0, mem words 0..3 = A,B,C,D -> id_valid 0 in BOOT; then
//     id_instr A@pc0, B@pc4, C@pc8 on consecutive edges; id_pc_plus4=id_pc+4.
//   2 stall high 3 cycles while id_instr=B -> B/pc4 held 3 cycles, imem_pc=8 held; resumes C.
//   3 redirect=1, redirect_pc=0x40 together with stall=1 -> next edge id_valid=0,
//     imem_pc=0x40; following edge id_pc=0x40, id_valid=1.
//   4 redirect_pc=0x42 -> imem_pc=0x40, misalign high exactly one cycle.
//   5 pc_q=0xFFFFFFFC advance -> id_pc=0xFFFFFFFC, id_pc_plus4=0, imem_pc=0.
//   6 (macro on) word 0x00100073 at pc 0x8 -> captured valid, then halted=1, id_valid=0,
//     imem_pc stuck 0xC; redirect 0x0 -> halted=0, refetch from 0. Macro off: no halt.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: instruction memory, pipeline control and IF/ID outputs
interface fetch_stage_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        misalign;
  logic        halted;

  modport master (
    output imem_pc, id_valid, id_pc, id_instr, id_pc_plus4, misalign, halted,
    input  imem_instr, stall, flush, redirect, redirect_pc
  );

  modport slave (
    input  imem_pc, id_valid, id_pc, id_instr, id_pc_plus4, misalign, halted,
    output imem_instr, stall, flush, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, redirect/stall/flush, halt on EBREAK
// Optional feature: define FETCH_HALT_EBREAK_EN to halt fetch after capturing EBREAK.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [31:0] WORD_MASK    = ~32'h0000_0003;

  state_t      state;
  logic [31:0] pc_q;
  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_plus4_q;
  logic        misalign_q;
  logic        halted_q;

  assign bus.imem_pc     = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.misalign    = misalign_q;
  assign bus.halted      = halted_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'h0000_0000;
      id_instr_q    <= NOP_INSTR;
      id_pc_plus4_q <= 32'h0000_0004;
      misalign_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state)
        BOOT: begin
          state <= RUN;
        end

        RUN: begin
          if (bus.redirect) begin
            pc_q       <= bus.redirect_pc & WORD_MASK;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            misalign_q <= |bus.redirect_pc[1:0];
          end else if (bus.flush) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            if (!bus.stall) begin
              pc_q <= pc_q + 32'd4;
            end
          end else if (!bus.stall) begin
            id_instr_q    <= bus.imem_instr;
            id_pc_q       <= pc_q;
            id_pc_plus4_q <= pc_q + 32'd4;
            id_valid_q    <= 1'b1;
            pc_q          <= pc_q + 32'd4;
`ifdef FETCH_HALT_EBREAK_EN
            if (bus.imem_instr == EBREAK_INSTR) begin
              state    <= HALT;
              halted_q <= 1'b1;
            end
`endif
          end
        end

        HALT: begin
          // A stall keeps the EBREAK visible in IF/ID until decode is ready.
          if (bus.redirect) begin
            pc_q       <= bus.redirect_pc & WORD_MASK;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
            misalign_q <= |bus.redirect_pc[1:0];
            state      <= RUN;
            halted_q   <= 1'b0;
          end else if (!bus.stall) begin
            id_valid_q <= 1'b0;
            id_instr_q <= NOP_INSTR;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] WA     = 32'hAAAA_0001;
  localparam logic [31:0] WB     = 32'hBBBB_0002;
  localparam logic [31:0] WC     = 32'hCCCC_0003;
  localparam logic [31:0] WD     = 32'hDDDD_0004;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] plus4;
    logic [31:0] ipc;
    logic        mis;
    logic        hlt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ebreak_mode;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  fetch_stage_if fif ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic eb);
    if (eb && a == 32'h8) return EBRK;
    case (a)
      32'h0:   return WA;
      32'h4:   return WB;
      32'h8:   return WC;
      32'hC:   return WD;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign fif.imem_instr = mem_word(fif.imem_pc, ebreak_mode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: one expectation per rising edge, compared on the following falling edge.
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      @(negedge clk);
      chk("id_valid",    {31'b0, fif.id_valid}, {31'b0, e.valid});
      chk("id_pc",       fif.id_pc,             e.pc);
      chk("id_instr",    fif.id_instr,          e.instr);
      chk("id_pc_plus4", fif.id_pc_plus4,       e.plus4);
      chk("imem_pc",     fif.imem_pc,           e.ipc);
      chk("misalign",    {31'b0, fif.misalign}, {31'b0, e.mis});
      chk("halted",      {31'b0, fif.halted},   {31'b0, e.hlt});
    end
  end

  task automatic step(input logic r, input logic s, input logic f, input logic rd,
                      input logic [31:0] rp, input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic [31:0] p4, input logic [31:0] ipc,
                      input logic mis, input logic hlt);
    exp_t e;
    rst_n           = r;
    fif.stall       = s;
    fif.flush       = f;
    fif.redirect    = rd;
    fif.redirect_pc = rp;
    e.valid = v; e.pc = pc; e.instr = ins; e.plus4 = p4; e.ipc = ipc; e.mis = mis; e.hlt = hlt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic hb;
`ifdef FETCH_HALT_EBREAK_EN
    hb = 1'b1;
`else
    hb = 1'b0;
`endif
    errors = 0; checks = 0; ebreak_mode = 1'b0;
    rst_n = 1'b0; fif.stall = 0; fif.flush = 0; fif.redirect = 0; fif.redirect_pc = 0;
    @(negedge clk);
    //   r  s  f  rd rp             v  pc             instr          plus4          imem_pc        mis hlt
    step(0, 0, 0, 0, 32'h0,         0, 32'h0,         NOP,           32'h4,         32'h0,         0, 0);
    step(0, 0, 0, 0, 32'h0,         0, 32'h0,         NOP,           32'h4,         32'h0,         0, 0);
    // BOOT edge, then A, B
    step(1, 0, 0, 0, 32'h0,         0, 32'h0,         NOP,           32'h4,         32'h0,         0, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'h0,         WA,            32'h4,         32'h4,         0, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'h4,         WB,            32'h8,         32'h8,         0, 0);
    // stall three edges holding B, then C
    step(1, 1, 0, 0, 32'h0,         1, 32'h4,         WB,            32'h8,         32'h8,         0, 0);
    step(1, 1, 0, 0, 32'h0,         1, 32'h4,         WB,            32'h8,         32'h8,         0, 0);
    step(1, 1, 0, 0, 32'h0,         1, 32'h4,         WB,            32'h8,         32'h8,         0, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'h8,         WC,            32'hC,         32'hC,         0, 0);
    // redirect with stall
    step(1, 1, 0, 1, 32'h40,        0, 32'h8,         NOP,           32'hC,         32'h40,        0, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'h40,        32'h5A5A_0040, 32'h44,        32'h44,        0, 0);
    // misaligned redirect
    step(1, 0, 0, 1, 32'h42,        0, 32'h40,        NOP,           32'h44,        32'h40,        1, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'h40,        32'h5A5A_0040, 32'h44,        32'h44,        0, 0);
    // flush advancing, flush with stall, then resume
    step(1, 0, 1, 0, 32'h0,         0, 32'h40,        NOP,           32'h44,        32'h48,        0, 0);
    step(1, 1, 1, 0, 32'h0,         0, 32'h40,        NOP,           32'h44,        32'h48,        0, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'h48,        32'h5A5A_0048, 32'h4C,        32'h4C,        0, 0);
    // wrap at top of address space
    step(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h48,        NOP,           32'h4C,        32'hFFFF_FFFC, 0, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'hA5A5_FFFC, 32'h0,         32'h0,         0, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'h0,         WA,            32'h4,         32'h4,         0, 0);
    // reset during a redirect wins, redirect dropped
    step(0, 1, 0, 1, 32'h80,        0, 32'h0,         NOP,           32'h4,         32'h0,         0, 0);
    step(1, 0, 0, 0, 32'h0,         0, 32'h0,         NOP,           32'h4,         32'h0,         0, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'h0,         WA,            32'h4,         32'h4,         0, 0);
    // EBREAK at 0x8
    ebreak_mode = 1'b1;
    step(1, 0, 0, 0, 32'h0,         1, 32'h4,         WB,            32'h8,         32'h8,         0, 0);
    step(1, 0, 0, 0, 32'h0,         1, 32'h8,         EBRK,          32'hC,         32'hC,         0, hb);
    if (hb) begin
      step(1, 0, 0, 0, 32'h0,       0, 32'h8,         NOP,           32'hC,         32'hC,         0, 1);
      step(1, 0, 0, 0, 32'h0,       0, 32'h8,         NOP,           32'hC,         32'hC,         0, 1);
      step(1, 0, 0, 1, 32'h0,       0, 32'h8,         NOP,           32'hC,         32'h0,         0, 0);
      step(1, 0, 0, 0, 32'h0,       1, 32'h0,         WA,            32'h4,         32'h4,         0, 0);
    end else begin
      step(1, 0, 0, 0, 32'h0,       1, 32'hC,         WD,            32'h10,        32'h10,        0, 0);
      step(1, 0, 0, 0, 32'h0,       1, 32'h10,        32'h5A5A_0010, 32'h14,        32'h14,        0, 0);
    end
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
